// File: rtl/alu_pkg.sv
// Shared definitions for the register/ALU execute sequencer.
//   - Default data path, register count and index widths
//   - ALU opcode constants ADD_OP..SRL_OP
//   - 2-bit FSM state encoding used by the sequencer
//   - op_is_legal(): true for the nine opcodes the ALU implements
package alu_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 16;
    localparam int DEF_ADDR_W   = 4;

    localparam logic [3:0] ADD_OP = 4'd1;
    localparam logic [3:0] SUB_OP = 4'd2;
    localparam logic [3:0] AND_OP = 4'd3;
    localparam logic [3:0] OR_OP  = 4'd4;
    localparam logic [3:0] XOR_OP = 4'd5;
    localparam logic [3:0] NOT_OP = 4'd6;
    localparam logic [3:0] SLA_OP = 4'd7;
    localparam logic [3:0] SRA_OP = 4'd8;
    localparam logic [3:0] SRL_OP = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op inside {ADD_OP, SUB_OP, AND_OP, OR_OP, XOR_OP,
                          NOT_OP, SLA_OP, SRA_OP, SRL_OP};
    endfunction

endpackage

// File: rtl/reg_alu_sequencer_reg_file.sv
// General-purpose register bank.
//   clk, rst              : clock, synchronous active-high reset (clears all entries)
//   we_i, waddr_i, wdata_i: single synchronous write port
//   raddr_a_i / rdata_a_o : combinational read port A
//   raddr_b_i / rdata_b_o : combinational read port B
//   dbg_addr_i/dbg_data_o : combinational debug read port
// R0 always reads as zero and ignores writes. Reads return the value held
// before any write on the same edge.
module reg_file
    import alu_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Index 0 is forced to zero on the read side as well, so R0 is zero
    // regardless of what the storage entry holds.
    assign rdata_a_o  = (raddr_a_i  == '0) ? '0 : regs_q[raddr_a_i];
    assign rdata_b_o  = (raddr_b_i  == '0) ? '0 : regs_q[raddr_b_i];
    assign dbg_data_o = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/reg_alu_sequencer.sv
// Single-issue execute sequencer sitting in front of the ALU.
//   clk, rst                     : clock, synchronous active-high reset
//   cmd_valid / cmd_ready        : command handshake (accepted on an edge where both are 1)
//   cmd_op, cmd_rd/rs/rt,
//   cmd_imm_sel, cmd_imm         : command fields, sampled only in IDLE
//   alu_a, alu_b, alu_op, alu_en : registered ALU operand/opcode/enable outputs
//   alu_res, alu_zero, alu_carry : ALU result and flags, sampled at the end of EXEC
//   done, cmd_err                : one-cycle retire pulse, error pulse for illegal opcode
//   flag_z, flag_c               : architectural zero/carry flags
//   dbg_addr / dbg_data          : combinational debug register read
//
// Handshake: a command transfers on a rising edge where cmd_valid=1 and
// cmd_ready=1. cmd_ready is high only in IDLE and never during reset; the
// command fields are ignored in every other cycle, so nothing is queued.
//
// Flow per command: IDLE -> READ (operands latched) -> EXEC (alu_en=1,
// result sampled) -> WB (writeback, done pulse) -> IDLE.
module reg_alu_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs,
    input  logic [ADDR_W-1:0] cmd_rt,
    input  logic              cmd_imm_sel,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    output logic              alu_en,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_zero,
    input  logic              alu_carry,
    output logic              done,
    output logic              cmd_err,
    output logic              flag_z,
    output logic              flag_c,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_e            state_q;

    // Captured command
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [ADDR_W-1:0] rs_q;
    logic [ADDR_W-1:0] rt_q;
    logic              imm_sel_q;
    logic [DATA_W-1:0] imm_q;

    // ALU-facing registers
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [3:0]        alu_op_q;
    logic              alu_en_q;

    // Result and flags sampled at the end of EXEC
    logic [DATA_W-1:0] res_q;
    logic              zero_q;
    logic              carry_q;

    // Architectural flags and retire pulses
    logic              flag_z_q;
    logic              flag_c_q;
    logic              done_q;
    logic              err_q;

    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic              wb_we;

    assign wb_we = (state_q == ST_WB) && op_is_legal(op_q);

    reg_file #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W)
    ) u_reg_file (
        .clk       (clk),
        .rst       (rst),
        .we_i      (wb_we),
        .waddr_i   (rd_q),
        .wdata_i   (res_q),
        .raddr_a_i (rs_q),
        .rdata_a_o (rdata_a),
        .raddr_b_i (rt_q),
        .rdata_b_o (rdata_b),
        .dbg_addr_i(dbg_addr),
        .dbg_data_o(dbg_data)
    );

    // Sequencer FSM. alu_en, done and cmd_err are registered and set on the
    // transition into the state that owns them, so they are high exactly
    // while the FSM is in EXEC (alu_en) or WB (done, cmd_err).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            imm_sel_q <= 1'b0;
            imm_q     <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            alu_en_q  <= 1'b0;
            res_q     <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= cmd_op;
                        rd_q      <= cmd_rd;
                        rs_q      <= cmd_rs;
                        rt_q      <= cmd_rt;
                        imm_sel_q <= cmd_imm_sel;
                        imm_q     <= cmd_imm;
                        state_q   <= ST_READ;
                    end
                end
                ST_READ: begin
                    alu_a_q  <= rdata_a;
                    alu_b_q  <= imm_sel_q ? imm_q : rdata_b;
                    alu_op_q <= op_q;
                    alu_en_q <= 1'b1;
                    state_q  <= ST_EXEC;
                end
                ST_EXEC: begin
                    res_q    <= alu_res;
                    zero_q   <= alu_zero;
                    carry_q  <= alu_carry;
                    alu_en_q <= 1'b0;
                    done_q   <= 1'b1;
                    err_q    <= !op_is_legal(op_q);
                    state_q  <= ST_WB;
                end
                ST_WB: begin
                    // Register write happens in the reg file via wb_we.
                    // Carry is only architecturally meaningful for ADD.
                    if (op_is_legal(op_q)) begin
                        flag_z_q <= zero_q;
                        if (op_q == ADD_OP) begin
                            flag_c_q <= carry_q;
                        end
                    end
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign alu_en    = alu_en_q;
    assign done      = done_q;
    assign cmd_err   = err_q;
    assign flag_z    = flag_z_q;
    assign flag_c    = flag_c_q;

endmodule

// File: tb/tb_reg_alu_sequencer.sv
module tb_reg_alu_sequencer;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int AW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_op = '0;
  logic [AW-1:0] cmd_rd = '0, cmd_rs = '0, cmd_rt = '0;
  logic          cmd_imm_sel = 1'b0;
  logic [DW-1:0] cmd_imm = '0;
  logic [DW-1:0] alu_a, alu_b, alu_res;
  logic [3:0]    alu_op;
  logic          alu_en, alu_zero, alu_carry;
  logic          done, cmd_err, flag_z, flag_c;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;

  logic [AW-1:0] drv_addr = '0;
  logic [AW-1:0] mon_addr = '0;
  logic          mon_active = 1'b0;
  assign dbg_addr = mon_active ? mon_addr : drv_addr;

  reg_alu_sequencer #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
    .cmd_imm_sel(cmd_imm_sel), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_en(alu_en),
    .alu_res(alu_res), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .done(done), .cmd_err(cmd_err), .flag_z(flag_z), .flag_c(flag_c),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // ---------------- behavioural ALU: returns {zero, carry, result} ----------------
  function automatic logic [33:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        c;
    logic [32:0] s;
    c = 1'b0;
    case (op)
      4'd1: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; end
      4'd2: begin r = a - b; c = (a < b); end
      4'd3: begin r = a & b; c = r[31]; end
      4'd4: begin r = a | b; c = r[31]; end
      4'd5: begin r = a ^ b; c = r[31]; end
      4'd6: begin r = ~a;    c = r[31]; end
      4'd7: begin r = b[0] ? (a << 1) : a; c = a[31]; end
      4'd8: begin r = b[0] ? 32'($signed(a) >>> 1) : a; c = a[0]; end
      4'd9: begin r = b[0] ? (a >> 1) : a; c = a[0]; end
      default: begin r = 32'hBAD0_0000 ^ a; c = 1'b1; end
    endcase
    if (op >= 4'd1 && op <= 4'd9) return {(r == 32'd0), c, r};
    return {1'b1, c, r};
  endfunction

  // The ALU drives the bus only while enabled; otherwise junk is presented
  logic [33:0] alu_out;
  assign alu_out   = alu_model(alu_op, alu_a, alu_b);
  assign alu_res   = alu_en ? alu_out[31:0] : 32'hDEAD_BEEF;
  assign alu_zero  = alu_en ? alu_out[33] : 1'b1;
  assign alu_carry = alu_en ? alu_out[32] : 1'b1;

  // ---------------- reference model ----------------
  logic [31:0] m_regs [NR];
  logic        m_z = 1'b0, m_c = 1'b0;

  typedef struct packed {
    logic [31:0] cyc;
    logic        err;
    logic [3:0]  rd;
    logic [31:0] val;
    logic        fz;
    logic        fc;
  } exp_t;
  exp_t exp_q[$];

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_run();
  end

  // ---------------- driver tasks ----------------
  task automatic drive_junk_fields();
    cmd_op      = 4'($urandom_range(0, 15));
    cmd_rd      = AW'($urandom_range(0, NR - 1));
    cmd_rs      = AW'($urandom_range(0, NR - 1));
    cmd_rt      = AW'($urandom_range(0, NR - 1));
    cmd_imm_sel = 1'($urandom_range(0, 1));
    cmd_imm     = $urandom;
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      failures++;
      $display("FAIL ready_timeout: cmd_ready got 0 expected 1 within 12 cycles");
      finish_run();
    end
  endtask

  // Issue one command and predict its outcome. Junk with cmd_valid=1 is held
  // through READ/EXEC/WB, which the sequencer must ignore.
  task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [3:0] rt, input logic sel, input logic [31:0] imm);
    logic [31:0] a, b;
    logic [33:0] o;
    logic        legal;
    exp_t        e;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt; cmd_imm_sel = sel; cmd_imm = imm;
    a = m_regs[rs];
    b = sel ? imm : m_regs[rt];
    o = alu_model(op, a, b);
    legal = (op >= 4'd1) && (op <= 4'd9);
    if (legal) begin
      if (rd != 4'd0) m_regs[rd] = o[31:0];
      m_z = o[33];
      if (op == 4'd1) m_c = o[32];
    end
    e.cyc = 32'(cyc + 3);
    e.err = !legal;
    e.rd  = rd;
    e.val = m_regs[rd];
    e.fz  = m_z;
    e.fc  = m_c;
    exp_q.push_back(e);
    repeat (3) begin
      @(negedge clk);
      drive_junk_fields();
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < NR; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      drv_addr = AW'(i);
      #1;
      check($sformatf("%s_R%0d", tag, i), dbg_data, m_regs[i]);
    end
  endtask

  task automatic random_cmd();
    logic [31:0] imm;
    case ($urandom_range(0, 3))
      0: imm = 32'd0;
      1: imm = 32'hFFFF_FFFF;
      2: imm = 32'($urandom_range(0, 3));
      default: imm = $urandom;
    endcase
    issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), imm);
    if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
  endtask

  // ---------------- monitor: pops expected entries on done ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 32'(done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", 32'(cyc), e.cyc);
          check("cmd_err", 32'(cmd_err), 32'(e.err));
          mon_addr = e.rd;
          mon_active = 1'b1;
          @(negedge clk);
          check("done_pulse_width", 32'(done), 32'd0);
          check("rd_value", dbg_data, e.val);
          check("flag_z", 32'(flag_z), 32'(e.fz));
          check("flag_c", 32'(flag_c), 32'(e.fc));
          mon_active = 1'b0;
        end
      end
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    int n;
    for (int i = 0; i < NR; i++) m_regs[i] = '0;

    repeat (3) @(negedge clk);
    check("ready_in_reset", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", 32'(cmd_ready), 32'd1);
    check("reset_flag_z", 32'(flag_z), 32'd0);
    check("reset_flag_c", 32'(flag_c), 32'd0);
    check("reset_alu_en", 32'(alu_en), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_cmd_err", 32'(cmd_err), 32'd0);
    check("reset_alu_a", alu_a, 32'd0);
    check("reset_alu_b", alu_b, 32'd0);
    check("reset_alu_op", 32'(alu_op), 32'd0);
    sweep("reset");

    // Directed sequence
    issue(4'd1, 4'd1, 4'd0, 4'd0, 1'b1, 32'h0000_0005);  // R1 = 5
    issue(4'd1, 4'd2, 4'd1, 4'd0, 1'b1, 32'hFFFF_FFFF);  // R2 = 4, carry
    issue(4'd2, 4'd3, 4'd1, 4'd1, 1'b0, 32'h0);          // R3 = 0, zero
    issue(4'hC, 4'd1, 4'd2, 4'd3, 1'b1, 32'h1234);       // illegal
    issue(4'd4, 4'd0, 4'd1, 4'd0, 1'b1, 32'h0000_00F0);  // write to R0
    idle_cycles(2);
    check("dir_R1", m_regs[1], 32'h5);
    check("dir_R2", m_regs[2], 32'h4);
    sweep("directed");

    // Randomized commands
    for (int i = 0; i < 150; i++) random_cmd();
    idle_cycles(2);
    sweep("random");

    // Reset while ADD R4 <- R1 + 1 is in EXEC; cmd_valid stays high
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op = 4'd1; cmd_rd = 4'd4; cmd_rs = 4'd1; cmd_rt = 4'd0; cmd_imm_sel = 1'b1; cmd_imm = 32'd1;
    @(negedge clk);
    drive_junk_fields();
    @(negedge clk);
    check("exec_alu_en", 32'(alu_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_alu_en", 32'(alu_en), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready_low", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    cmd_valid = 1'b0;
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_z = 1'b0;
    m_c = 1'b0;
    #1;
    check("rst_ready_high", 32'(cmd_ready), 32'd1);
    check("rst_flag_z", 32'(flag_z), 32'd0);
    check("rst_flag_c", 32'(flag_c), 32'd0);
    sweep("midreset");

    // A few more after the mid-command reset
    for (int i = 0; i < 30; i++) random_cmd();
    idle_cycles(2);
    sweep("final");

    // Drain the expected queue with a bounded wait
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    finish_run();
  end

endmodule
